// File: rtl/div_seq_if.sv
// Operand and result valid/ready bundle between the FP divide front end and div_seq_ctrl.
// master = front end (requests operands, consumes results); slave = the sequencer.
interface div_seq_if #(
    parameter int N = 26
);
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] in_z;
    logic [N-1:0]   in_d;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_q;
    logic [N-1:0]   out_r;
    logic           out_dbz;
    logic           out_ovf;

    modport master (
        output in_valid, in_z, in_d, out_ready,
        input  in_ready, out_valid, out_q, out_r, out_dbz, out_ovf
    );

    modport slave (
        input  in_valid, in_z, in_d, out_ready,
        output in_ready, out_valid, out_q, out_r, out_dbz, out_ovf
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencer for the shift-subtract mantissa divider: loads operands, counts N iterations,
// captures quotient/remainder. Optional macro DIV_ABORT_EN adds an abort input.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// LOAD  | dv_load_n=0 for one cycle so the divider loads dv_z/dv_d
// RUN   | divider iterating, cnt counts 0..N-1
// CAPT  | last iteration settled, capture dv_q/dv_r next edge
// DONE  | result held on out_* until out_ready
module div_seq_ctrl #(
    parameter int N = 26
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef DIV_ABORT_EN
    input  logic           abort,
`endif
    div_seq_if.slave       bus,
    output logic           busy,
    output logic           dv_load_n,
    output logic [2*N-1:0] dv_z,
    output logic [N-1:0]   dv_d,
    input  logic [N-1:0]   dv_q,
    input  logic [N-1:0]   dv_r
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_CAPT,
        ST_DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             dv_load_n_q;
    logic [2*N-1:0]   dv_z_q;
    logic [N-1:0]     dv_d_q;
    logic [N-1:0]     out_q_q;
    logic [N-1:0]     out_r_q;
    logic             out_dbz_q;
    logic             out_ovf_q;

    logic             accept_d;
    logic             dbz_d;
    logic             ovf_d;
    logic             abort_d;

    assign accept_d = bus.in_valid && (state_q == ST_IDLE);
    assign dbz_d    = (bus.in_d == '0);
    assign ovf_d    = !dbz_d && (bus.in_z[2*N-1:N] >= bus.in_d);

`ifdef DIV_ABORT_EN
    assign abort_d = abort && ((state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_CAPT));
`else
    assign abort_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dv_load_n_q <= 1'b0;
            dv_z_q      <= '0;
            dv_d_q      <= '0;
            out_q_q     <= '0;
            out_r_q     <= '0;
            out_dbz_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else if (abort_d) begin
            // Output registers deliberately untouched: the previous result stays readable.
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dv_load_n_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        dv_z_q    <= bus.in_z;
                        dv_d_q    <= bus.in_d;
                        out_ovf_q <= ovf_d;
                        out_dbz_q <= dbz_d;
                        if (dbz_d) begin
                            // Zero divisor never touches the datapath.
                            out_q_q <= '1;
                            out_r_q <= '0;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    state_q     <= ST_RUN;
                    dv_load_n_q <= 1'b1;
                    cnt_q       <= '0;
                end
                ST_RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    out_q_q     <= dv_q;
                    out_r_q     <= dv_r;
                    dv_load_n_q <= 1'b0;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    dv_load_n_q <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_q     = out_q_q;
    assign bus.out_r     = out_r_q;
    assign bus.out_dbz   = out_dbz_q;
    assign bus.out_ovf   = out_ovf_q;
    assign busy          = (state_q != ST_IDLE);
    assign dv_load_n     = dv_load_n_q;
    assign dv_z          = dv_z_q;
    assign dv_d          = dv_d_q;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl (N=8) with a behavioural divider that only presents the right
// answer after exactly N iterating edges; results checked against plain integer division.
module tb_div_seq_ctrl;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_seq_if #(.N(N)) bus ();

    logic           busy;
    logic           dv_load_n;
    logic [2*N-1:0] dv_z;
    logic [N-1:0]   dv_d;
    logic [N-1:0]   dv_q;
    logic [N-1:0]   dv_r;
`ifdef DIV_ABORT_EN
    logic           abort = 1'b0;
`endif

    div_seq_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef DIV_ABORT_EN
        .abort     (abort),
`endif
        .bus       (bus),
        .busy      (busy),
        .dv_load_n (dv_load_n),
        .dv_z      (dv_z),
        .dv_d      (dv_d),
        .dv_q      (dv_q),
        .dv_r      (dv_r)
    );

    // Divider model: counts edges with load released; answer valid only at exactly N.
    int it_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          it_cnt <= 0;
        else if (!dv_load_n) it_cnt <= 0;
        else if (it_cnt < N + 4) it_cnt <= it_cnt + 1;
    end

    logic [2*N-1:0] mq16, mr16;
    always_comb begin
        mq16 = '0;
        mr16 = '0;
        if (it_cnt == N && dv_d != '0) begin
            mq16 = dv_z / {8'b0, dv_d};
            mr16 = dv_z % {8'b0, dv_d};
            dv_q = mq16[N-1:0];
            dv_r = mr16[N-1:0];
        end else begin
            dv_q = 8'h5A ^ 8'(it_cnt);
            dv_r = 8'hA5;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] z, input logic [7:0] d, input int hold);
        logic [15:0] q16, r16;
        logic [N-1:0] eq, er, sq, sr;
        logic edbz, eovf;
        int elat, cyc;
        bit rdy_bad, ld_hi, hold_bad;

        edbz = (d == 8'd0);
        eovf = !edbz && (z[15:8] >= d);
        if (edbz) begin
            eq = 8'hFF; er = 8'h00; elat = 0;
        end else begin
            q16 = z / {8'b0, d};
            r16 = z % {8'b0, d};
            eq = q16[7:0]; er = r16[7:0]; elat = N + 2;
        end

        @(negedge clk);
        check("in_ready_idle", {63'b0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        bus.in_z = z;
        bus.in_d = d;
        bus.out_ready = 1'b0;
        cyc = 0; rdy_bad = 0; ld_hi = 0;
        do begin
            @(negedge clk);
            cyc++;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_z = 16'($urandom);
            bus.in_d = 8'($urandom);
            if (bus.in_ready) rdy_bad = 1;
            if (dv_load_n) ld_hi = 1;
        end while (!bus.out_valid && cyc < 40);

        check("out_valid_seen", {63'b0, bus.out_valid}, 64'd1);
        check("latency", 64'(cyc - 1), 64'(elat));
        check("in_ready_busy", {63'b0, rdy_bad}, 64'd0);
        check("load_released", {63'b0, ld_hi}, {63'b0, !edbz});
        check("dbz", {63'b0, bus.out_dbz}, {63'b0, edbz});
        check("ovf", {63'b0, bus.out_ovf}, {63'b0, eovf});
        if (!eovf) begin
            check("quot", {56'b0, bus.out_q}, {56'b0, eq});
            check("rem", {56'b0, bus.out_r}, {56'b0, er});
        end

        sq = bus.out_q; sr = bus.out_r; hold_bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_z = 16'($urandom);
            bus.in_d = 8'($urandom);
            if (!bus.out_valid || bus.in_ready || bus.out_q !== sq || bus.out_r !== sr) hold_bad = 1;
        end
        if (hold > 0) check("hold_stable", {63'b0, hold_bad}, 64'd0);

        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("idle_after_hs", {62'b0, bus.in_ready, bus.out_valid}, 64'd2);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] rz;
        logic [7:0] rd;

        bus.in_valid = 1'b0;
        bus.in_z = '0;
        bus.in_d = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", {52'b0, bus.out_valid, bus.out_dbz, bus.out_ovf, dv_load_n, busy, bus.in_ready,
                            bus.out_q == 8'd0, bus.out_r == 8'd0, dv_z == 16'd0, dv_d == 8'd0, 2'b0},
              {52'b0, 4'b0000, 1'b0, 1'b1, 4'b1111, 2'b0});
        rst_n = 1'b1;

        run_op(16'd11, 8'd3, 0);
        run_op(16'h1234, 8'd0, 1);
        run_op(16'h0500, 8'd3, 0);
        run_op(16'h0200, 8'd3, 5);
        run_op(16'h00FF, 8'd255, 2);

        for (int k = 0; k < 30; k++) begin
            rd = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            rz = 16'($urandom);
            if (rd != 8'd0 && $urandom_range(0, 2) != 0)
                rz[15:8] = 8'($urandom_range(0, int'(rd) - 1));
            run_op(rz, rd, $urandom_range(0, 3));
        end

        // Mid-RUN reset.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_z = 16'd11; bus.in_d = 8'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_rst", {62'b0, busy, dv_load_n}, 64'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", {56'b0, bus.out_valid, bus.out_dbz, bus.out_ovf, dv_load_n, busy, bus.in_ready,
                                bus.out_q == 8'd0 && bus.out_r == 8'd0, dv_z == 16'd0 && dv_d == 8'd0},
              {56'b0, 8'b00000111});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", {63'b0, bus.in_ready}, 64'd1);

`ifdef DIV_ABORT_EN
        run_op(16'd11, 8'd3, 0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_z = 16'h0200; bus.in_d = 8'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", {61'b0, bus.in_ready, bus.out_valid, dv_load_n}, 64'd4);
        check("abort_keep_q", {56'b0, bus.out_q}, 64'd3);
        repeat (12) @(negedge clk);
        check("abort_no_valid", {63'b0, bus.out_valid}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
